word_serializer: RTL and testbench



---
 rtl/word_serializer.sv | 97 +++++++++
 tb/tb_word_serializer.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/word_serializer.sv
// word_serializer: parallel-to-serial transmitter, LSB first, valid/ready on both sides.
// Optional feature macro: SERIALIZER_PARITY_EN appends one even-parity beat after the
// data bits; S_last then moves from data bit WIDTH-1 to the parity beat.
module word_serializer #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             C,
  input  logic             R,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] D,
  output logic             S,
  output logic             S_valid,
  output logic             S_last,
  input  logic             S_ready
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

`ifdef SERIALIZER_PARITY_EN
  // Parity beat sits at index WIDTH, after all data bits.
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH);
`else
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);
`endif

  typedef enum logic {
    StIdle,
    StShift
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] shreg_q;
  logic [CntW-1:0]  cnt_q;
  logic             cur_bit;

`ifdef SERIALIZER_PARITY_EN
  logic par_q;

  // Parity bit captured with the word and held until the word completes.
  always_ff @(posedge C or posedge R) begin
    if (R) begin
      par_q <= 1'b0;
    end else if (state_q == StIdle && load_valid) begin
      par_q <= ^D;
    end
  end

  // The parity beat replaces the (already drained) shift register output.
  always_comb begin
    cur_bit = (cnt_q == CntW'(WIDTH)) ? par_q : shreg_q[0];
  end
`else
  // Data bit under presentation is always the LSB of the shift register.
  always_comb begin
    cur_bit = shreg_q[0];
  end
`endif

  // Load/shift FSM: accepts a word in idle, shifts one bit per accepted beat.
  always_ff @(posedge C or posedge R) begin
    if (R) begin
      state_q <= StIdle;
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (load_valid) begin
            shreg_q <= D;
            cnt_q   <= '0;
            state_q <= StShift;
          end
        end
        StShift: begin
          if (S_ready) begin
            shreg_q <= {1'b0, shreg_q[WIDTH-1:1]};
            cnt_q   <= cnt_q + 1'b1;
            if (cnt_q == LastCnt) begin
              state_q <= StIdle;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Outputs follow the registered state; R forces load_ready low while held.
  always_comb begin
    S_valid    = (state_q == StShift);
    load_ready = (state_q == StIdle) && !R;
    S          = S_valid && cur_bit;
    S_last     = S_valid && (cnt_q == LastCnt);
  end

endmodule

// File: tb/tb_word_serializer.sv
// Bench for word_serializer: scoreboard queue of expected serial bits, filled on
// word acceptance and drained on each accepted beat; directed steps in one block.
module tb_word_serializer;

  localparam int unsigned WIDTH = 32;

  logic             C = 1'b0;
  logic             R;
  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] D;
  logic             S;
  logic             S_valid;
  logic             S_last;
  logic             S_ready;

  int n_vec = 0;
  int n_err = 0;

  bit   exp_q[$];
  bit   exp_idle = 1'b1;
  int   n_beats = 0;
  int   idle_run = 0;
  int   last_gap = -1;
  logic prev_valid = 1'b0;

  word_serializer #(.WIDTH(WIDTH)) dut (
    .C          (C),
    .R          (R),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .D          (D),
    .S          (S),
    .S_valid    (S_valid),
    .S_last     (S_last),
    .S_ready    (S_ready)
  );

  always #5 C = ~C;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: sample at negedge against the model, update the model, then
  // return 1 time unit after the next rising edge for input changes.
  task automatic tick();
    @(negedge C);
    if (R) begin
      exp_q.delete();
      exp_idle = 1'b1;
    end
    check("load_ready", {31'b0, load_ready}, {31'b0, exp_idle && !R});
    check("S_valid", {31'b0, S_valid}, {31'b0, !exp_idle});
    if (exp_idle) begin
      check("S_idle", {31'b0, S}, 32'd0);
      check("S_last_idle", {31'b0, S_last}, 32'd0);
    end else begin
      check("S_bit", {31'b0, S}, {31'b0, exp_q[0]});
      check("S_last", {31'b0, S_last}, {31'b0, exp_q.size() == 1});
      if (S_ready) begin
        void'(exp_q.pop_front());
        n_beats++;
        if (exp_q.size() == 0) exp_idle = 1'b1;
      end
    end
    if (S_valid && !prev_valid) last_gap = idle_run;
    idle_run   = S_valid ? 0 : idle_run + 1;
    prev_valid = S_valid;
    if (!exp_idle || S_valid) begin
      // busy: load ignored
    end else if (!R && load_valid) begin
      for (int i = 0; i < WIDTH; i++) exp_q.push_back(D[i]);
`ifdef SERIALIZER_PARITY_EN
      exp_q.push_back(^D);
`endif
      exp_idle = 1'b0;
      n_beats  = 0;
    end
    @(posedge C);
    #1;
  endtask

  // Drain the current word; pat 1 drives S_ready as 1,0,0,1,0,0,...
  task automatic run_word(input int pat, input int budget);
    int k = 0;
    while (!exp_idle && k < budget) begin
      S_ready = (pat == 0) ? 1'b1 : (k % 3 == 0);
      tick();
      k++;
    end
    check("word_done_in_budget", {31'b0, exp_idle}, 32'd1);
    S_ready = 1'b1;
  endtask

  task automatic send(input logic [WIDTH-1:0] w, input int pat);
    D          = w;
    load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    run_word(pat, 200);
`ifdef SERIALIZER_PARITY_EN
    check("beat_count", n_beats, WIDTH + 1);
`else
    check("beat_count", n_beats, WIDTH);
`endif
  endtask

  initial begin
    // Reset held with a word offered: nothing may be captured.
    R          = 1'b1;
    load_valid = 1'b1;
    D          = 32'hFFFF_FFFF;
    S_ready    = 1'b1;
    @(posedge C);
    #1;
    for (int i = 0; i < 3; i++) tick();
    R          = 1'b0;
    load_valid = 1'b0;
    tick();
    tick();

    // Single word, full-rate drain.
    send(32'hA5A5_0F01, 0);
    tick();

    // Backpressure pattern.
    send(32'h8000_0001, 1);
    tick();

    // Back-to-back with load_valid held high.
    D          = 32'hFFFF_FFFF;
    load_valid = 1'b1;
    tick();
    D = 32'h0000_0000;
    run_word(0, 200);
    tick();
    load_valid = 1'b0;
    run_word(0, 200);
    check("b2b_gap", last_gap, 1);
    tick();

    // Reset mid-word after 10 accepted beats.
    D          = 32'h1234_5678;
    load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    for (int i = 0; i < 40 && n_beats < 10; i++) tick();
    check("beats_before_reset", n_beats, 10);
    R = 1'b1;
    #1;
    check("async_S_valid", {31'b0, S_valid}, 32'd0);
    check("async_load_ready", {31'b0, load_ready}, 32'd0);
    check("async_S", {31'b0, S}, 32'd0);
    #1;
    @(posedge C);
    #1;
    tick();
    R = 1'b0;
    send(32'h0000_000F, 0);
    tick();

    // Parity-sensitive words (plain words in the default build).
    send(32'h0000_0007, 0);
    tick();
    send(32'h0000_0003, 1);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
